fpalu_cmd_issuer: RTL

- Initiator for the FPalu start/busy/valid interface.
- Buffers upstream floating-point commands (A, B, opcode, tag) in a small FIFO and issues them to FPalu one at a time.
- Pulses start for sequential opcodes, or waits a fixed settle time for combinational opcodes.
- Captures Out and the unf/ovf/zbz/dbz flags into a result register drained by a valid/ready handshake. Guards each operation with a timeout.

---
 rtl/fpalu_pkg.sv | 28 ++
 rtl/fpalu_cmd_fifo.sv | 54 +++++
 rtl/fpalu_cmd_issuer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/fpalu_pkg.sv
// Shared opcodes, FSM states and flag layout for the FPalu command issuer.
package fpalu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned FLAG_W = 4;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_MUL = 3'b010;
   localparam logic [OP_W-1:0] OP_DIV = 3'b011;
   localparam logic [OP_W-1:0] OP_SHF = 3'b100;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_SEQ  = 2'd2,
      WAIT_COMB = 2'd3
   } state_t;

   typedef struct packed {
      logic unf;
      logic ovf;
      logic zbz;
      logic dbz;
   } fpalu_flags_t;

endpackage

// File: rtl/fpalu_cmd_fifo.sv
// Small synchronous FIFO holding packed upstream commands.
module fpalu_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 71
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/fpalu_cmd_issuer.sv
// Buffers FP commands and issues them one at a time to FPalu, capturing results.
module fpalu_cmd_issuer
   import fpalu_pkg::*;
#(
   parameter int unsigned CMD_DEPTH = 4,
   parameter int unsigned TAG_W     = 4,
   parameter logic [7:0]  SEQ_MASK  = 8'b0000_1000,
   parameter int unsigned COMB_LAT  = 2,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic [2:0]       cmd_op,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [2:0]       alu_op,
   output logic             alu_cin,
   output logic             alu_start,
   input  logic             alu_busy,
   input  logic             alu_valid,
   input  logic [31:0]      alu_out,
   input  logic [3:0]       alu_flags,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data,
   output logic [3:0]       res_flags,
   output logic [TAG_W-1:0] res_tag,
   output logic             res_timeout
);

   localparam int unsigned CMD_W   = 2*DATA_W + OP_W + TAG_W;
   localparam int unsigned TMR_MAX = (TIMEOUT > COMB_LAT) ? TIMEOUT : COMB_LAT;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0] COMB_LAST = TMR_W'(COMB_LAT - 1);

   state_t            state, state_d;
   logic [TMR_W-1:0]  timer, timer_d;
   logic [CMD_W-1:0]  fifo_din;
   logic [CMD_W-1:0]  head_cmd;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic [31:0]       head_a;
   logic [31:0]       head_b;
   logic [2:0]        head_op;
   logic [TAG_W-1:0]  head_tag;
   logic [TAG_W-1:0]  tag_q;
   logic              start_d;
   logic              cap_ok;
   logic              cap_to;
   logic              res_free;
   fpalu_flags_t      flags_in;
   logic              unused_busy;

   assign cmd_ready   = !fifo_full;
   assign fifo_push   = cmd_valid && cmd_ready;
   assign fifo_din    = {cmd_tag, cmd_op, cmd_b, cmd_a};
   assign head_a      = head_cmd[DATA_W-1:0];
   assign head_b      = head_cmd[2*DATA_W-1:DATA_W];
   assign head_op     = head_cmd[2*DATA_W+OP_W-1:2*DATA_W];
   assign head_tag    = head_cmd[CMD_W-1:2*DATA_W+OP_W];
   assign alu_cin     = 1'b0;
   assign res_free    = !res_valid || res_ready;
   assign flags_in    = fpalu_flags_t'(alu_flags);
   assign unused_busy = alu_busy;

   fpalu_cmd_fifo #(
      .DEPTH (CMD_DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (fifo_din),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (head_cmd)
   );

   // FSM state and wait timer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_d;
         timer <= timer_d;
      end
   end

   // Next-state, timer and capture strobes; a free result slot gates every issue.
   always_comb begin
      state_d  = state;
      timer_d  = timer;
      fifo_pop = 1'b0;
      start_d  = 1'b0;
      cap_ok   = 1'b0;
      cap_to   = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty && res_free) begin
               fifo_pop = 1'b1;
               start_d  = SEQ_MASK[head_op];
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = SEQ_MASK[alu_op] ? WAIT_SEQ : WAIT_COMB;
         end
         WAIT_SEQ: begin
            if (alu_valid) begin
               cap_ok  = 1'b1;
               state_d = IDLE;
            end else if (timer == TMO_LAST) begin
               cap_to  = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer + TMR_W'(1);
            end
         end
         WAIT_COMB: begin
            if (timer == COMB_LAST) begin
               cap_ok  = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer + TMR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand registers hold from issue until the next command is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         tag_q     <= '0;
         alu_start <= 1'b0;
      end else begin
         alu_start <= start_d;
         if (fifo_pop) begin
            alu_a  <= head_a;
            alu_b  <= head_b;
            alu_op <= head_op;
            tag_q  <= head_tag;
         end
      end
   end

   // Result register: a capture takes priority over a downstream drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_flags   <= '0;
         res_tag     <= '0;
         res_timeout <= 1'b0;
      end else if (cap_ok || cap_to) begin
         res_valid   <= 1'b1;
         res_data    <= cap_ok ? alu_out : 32'h0;
         res_flags   <= cap_ok ? FLAG_W'(flags_in) : 4'h0;
         res_tag     <= tag_q;
         res_timeout <= cap_to;
      end else if (res_ready) begin
         res_valid   <= 1'b0;
      end
   end

endmodule
